// File: rtl/gemm_tile_sequencer.sv
// GeMM tile sequencer: block-tiled A/B read address generation with MAC strobes,
// credit-limited tile issue and a buffered ready/valid write-back path to SRAM C.
module gemm_tile_sequencer #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int CDataWidth    = 128,
  parameter int ReadLatency   = 1,
  parameter int OutFifoDepth  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     a_base_i,
  input  logic [AddrWidth-1:0]     b_base_i,
  input  logic [AddrWidth-1:0]     c_base_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic                     sram_rd_en_o,
  output logic                     mac_valid_o,
  output logic                     mac_init_o,
  output logic                     mac_last_o,
  input  logic                     c_valid_i,
  input  logic [CDataWidth-1:0]    c_data_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic [CDataWidth-1:0]    sram_c_wdata_o,
  output logic                     sram_c_we_o,
  input  logic                     sram_c_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int PtrW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
  localparam int CntW = $clog2(OutFifoDepth + 1) + 1;
  localparam logic [CntW-1:0]          Depth   = CntW'(OutFifoDepth);
  localparam logic [CntW-1:0]          CntOne  = CntW'(1);
  localparam logic [PtrW-1:0]          PtrLast = PtrW'(OutFifoDepth - 1);
  localparam logic [PtrW-1:0]          PtrOne  = PtrW'(1);
  localparam logic [SizeAddrWidth-1:0] SizeOne = SizeAddrWidth'(1);
  localparam logic [AddrWidth-1:0]     AddrOne = AddrWidth'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [SizeAddrWidth-1:0] msize_q, msize_d, ksize_q, ksize_d, nsize_q, nsize_d;
  logic [AddrWidth-1:0]     a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [SizeAddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AddrWidth-1:0]     a_row_q, a_row_d, b_row_q, b_row_d;
  logic [AddrWidth-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [SizeAddrWidth-1:0] mw_q, mw_d, nw_q, nw_d;
  logic [AddrWidth-1:0]     c_addr_q, c_addr_d;
  logic [CntW-1:0]          inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ReadLatency-1:0]   vld_pipe_q, vld_pipe_d, init_pipe_q, init_pipe_d;
  logic [ReadLatency-1:0]   last_pipe_q, last_pipe_d;
  logic                     err_q, err_d;
  logic [CDataWidth-1:0]    fifo_mem [1<<PtrW];

  logic load, size_zero, k_first, k_last, n_last, m_last, credit_ok;
  logic issue, last_read, tile_open, push, pop, wr_last;
  logic [AddrWidth-1:0] k_step, a_addr_cur, b_addr_cur;

  assign load       = (state_q == IDLE) && start_i;
  assign size_zero  = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign k_first    = (k_q == '0);
  assign k_last     = (k_q == ksize_q - SizeOne);
  assign n_last     = (n_q == nsize_q - SizeOne);
  assign m_last     = (m_q == msize_q - SizeOne);
  // A new tile may only start if its result is guaranteed a FIFO slot.
  assign credit_ok  = (inflight_q + fifo_cnt_q) < Depth;
  assign issue      = (state_q == ISSUE) && (!k_first || credit_ok);
  assign tile_open  = issue && k_first;
  assign last_read  = issue && k_last && n_last && m_last;
  assign push       = c_valid_i && (inflight_q != '0);
  assign pop        = sram_c_we_o && sram_c_ready_i;
  assign wr_last    = pop && (mw_q == msize_q - SizeOne) && (nw_q == nsize_q - SizeOne);
  assign k_step     = AddrWidth'(ksize_q);
  assign a_addr_cur = a_row_q + AddrWidth'(k_q);
  assign b_addr_cur = b_row_q + AddrWidth'(k_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = size_zero ? DONE : ISSUE;
      ISSUE:   if (last_read) state_d = DRAIN;
      DRAIN:   if (wr_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row bases track a_base + m*K and b_base + n*K incrementally, avoiding multipliers.
  always_comb begin
    msize_d  = msize_q;  ksize_d  = ksize_q;  nsize_d  = nsize_q;
    a_base_d = a_base_q; b_base_d = b_base_q; c_base_d = c_base_q;
    m_d      = m_q;      n_d      = n_q;      k_d      = k_q;
    a_row_d  = a_row_q;  b_row_d  = b_row_q;
    a_addr_d = a_addr_q; b_addr_d = b_addr_q;
    mw_d     = mw_q;     nw_d     = nw_q;     c_addr_d = c_addr_q;
    err_d    = err_q;
    if (load) begin
      msize_d  = M_size_i; ksize_d  = K_size_i; nsize_d  = N_size_i;
      a_base_d = a_base_i; b_base_d = b_base_i; c_base_d = c_base_i;
      m_d      = '0;       n_d      = '0;       k_d      = '0;
      a_row_d  = a_base_i; b_row_d  = b_base_i;
      mw_d     = '0;       nw_d     = '0;       c_addr_d = c_base_i;
      err_d    = size_zero;
    end else begin
      if (issue) begin
        a_addr_d = a_addr_cur;
        b_addr_d = b_addr_cur;
        if (!k_last) begin
          k_d = k_q + SizeOne;
        end else begin
          k_d = '0;
          if (!n_last) begin
            n_d     = n_q + SizeOne;
            b_row_d = b_row_q + k_step;
          end else begin
            n_d     = '0;
            b_row_d = b_base_q;
            m_d     = m_q + SizeOne;
            a_row_d = a_row_q + k_step;
          end
        end
      end
      if (pop) begin
        c_addr_d = c_addr_q + AddrOne;
        if (nw_q == nsize_q - SizeOne) begin
          nw_d = '0;
          mw_d = mw_q + SizeOne;
        end else begin
          nw_d = nw_q + SizeOne;
        end
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (tile_open && !push)      inflight_d = inflight_q + CntOne;
    else if (push && !tile_open) inflight_d = inflight_q - CntOne;
    if (push && !pop)            fifo_cnt_d = fifo_cnt_q + CntOne;
    else if (pop && !push)       fifo_cnt_d = fifo_cnt_q - CntOne;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
  end

  // Strobes mirror the read issue, delayed to line up with SRAM data at the MAC.
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    init_pipe_d    = init_pipe_q;
    last_pipe_d    = last_pipe_q;
    vld_pipe_d[0]  = issue;
    init_pipe_d[0] = tile_open;
    last_pipe_d[0] = issue && k_last;
    for (int i = 1; i < ReadLatency; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      init_pipe_d[i] = init_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      msize_q     <= '0; ksize_q  <= '0; nsize_q  <= '0;
      a_base_q    <= '0; b_base_q <= '0; c_base_q <= '0;
      m_q         <= '0; n_q      <= '0; k_q      <= '0;
      a_row_q     <= '0; b_row_q  <= '0;
      a_addr_q    <= '0; b_addr_q <= '0;
      mw_q        <= '0; nw_q     <= '0; c_addr_q <= '0;
      inflight_q  <= '0; fifo_cnt_q <= '0;
      wr_ptr_q    <= '0; rd_ptr_q   <= '0;
      vld_pipe_q  <= '0; init_pipe_q <= '0; last_pipe_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      msize_q     <= msize_d;  ksize_q  <= ksize_d;  nsize_q  <= nsize_d;
      a_base_q    <= a_base_d; b_base_q <= b_base_d; c_base_q <= c_base_d;
      m_q         <= m_d;      n_q      <= n_d;      k_q      <= k_d;
      a_row_q     <= a_row_d;  b_row_q  <= b_row_d;
      a_addr_q    <= a_addr_d; b_addr_q <= b_addr_d;
      mw_q        <= mw_d;     nw_q     <= nw_d;     c_addr_q <= c_addr_d;
      inflight_q  <= inflight_d; fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;   rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q  <= vld_pipe_d; init_pipe_q <= init_pipe_d; last_pipe_q <= last_pipe_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= c_data_i;
  end

  assign sram_rd_en_o   = issue;
  assign sram_a_addr_o  = issue ? a_addr_cur : a_addr_q;
  assign sram_b_addr_o  = issue ? b_addr_cur : b_addr_q;
  assign mac_valid_o    = vld_pipe_q[ReadLatency-1];
  assign mac_init_o     = init_pipe_q[ReadLatency-1];
  assign mac_last_o     = last_pipe_q[ReadLatency-1];
  assign sram_c_we_o    = (fifo_cnt_q != '0);
  assign sram_c_wdata_o = sram_c_we_o ? fifo_mem[rd_ptr_q] : '0;
  assign sram_c_addr_o  = c_addr_q;
  assign busy_o         = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;

endmodule
